// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential comparator:
//   state_t   - controller state encoding (IDLE / RUN / DONE)
//   ceil_div  - integer ceiling division, used to size the chunk count
// Optional feature macro used by the comparator: CMP_SIGNED_EN.
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// -----------------------------------------------------------------------------
// chunk_subtractor
// Combinational DIGIT_W-bit ripple-borrow subtractor: diff = a - b - borrow_in.
// Ports:
//   a, b        in   DIGIT_W  minuend / subtrahend digit
//   borrow_in   in   1        borrow from the less significant digit
//   diff        out  DIGIT_W  difference digit
//   borrow_out  out  1        borrow into the next digit
// -----------------------------------------------------------------------------
module chunk_subtractor #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] diff,
  output logic               borrow_out
);

  always_comb begin
    logic w_bw;
    w_bw = borrow_in;
    diff = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      diff[i] = a[i] ^ b[i] ^ w_bw;
      // Borrow when a<b at this bit, or when equal and a borrow is pending.
      w_bw    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bw);
    end
    borrow_out = w_bw;
  end

endmodule

// File: rtl/seq_comparator.sv
// -----------------------------------------------------------------------------
// seq_comparator
// Multi-cycle magnitude comparator. Operands are captured on start and
// subtracted one DIGIT_W-bit digit per cycle (LSB digit first) through a
// single shared chunk_subtractor. Flags are produced when the last digit is
// done, together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH    operand width (>= 2)
//   DIGIT_W  bits processed per cycle (1..WIDTH)
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request; operands captured only when idle
//   number1      in   WIDTH  minuend
//   number2      in   WIDTH  subtrahend
//   signed_mode  in   1      (CMP_SIGNED_EN only) 1 = two's-complement compare
//   busy         out  1      high in RUN and DONE
//   done         out  1      one-cycle pulse when flags are updated
//   zero_flag    out  1      number1 == number2
//   carry_flag   out  1      number1 < number2
// Configuration macro: CMP_SIGNED_EN adds signed_mode and the signed compare.
// -----------------------------------------------------------------------------
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam int NCHUNK   = ceil_div(WIDTH, DIGIT_W);
  localparam int PAD_W    = NCHUNK * DIGIT_W;
  // Number of real operand bits living in the top digit (1..DIGIT_W).
  localparam int TOP_BITS = WIDTH - (NCHUNK - 1) * DIGIT_W;
  localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [DIGIT_W-1:0] TOP_MASK = {DIGIT_W{1'b1}} >> (DIGIT_W - TOP_BITS);

  state_t             r_state;
  logic [PAD_W-1:0]   r_a;
  logic [PAD_W-1:0]   r_b;
  logic               r_borrow;
  logic               r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_zero;
  logic               r_carry;
`ifdef CMP_SIGNED_EN
  logic               r_signed;
`endif

  logic [DIGIT_W-1:0] w_a;
  logic [DIGIT_W-1:0] w_b;
  logic [DIGIT_W-1:0] w_diff;
  logic [DIGIT_W-1:0] w_mask;
  logic               w_bout;
  logic               w_last;
  logic               w_acc_next;
  logic               w_carry;

  // Operands shift right each RUN cycle, so the current digit is always the
  // low DIGIT_W bits.
  assign w_a = r_a[DIGIT_W-1:0];
  assign w_b = r_b[DIGIT_W-1:0];

  chunk_subtractor #(
    .DIGIT_W (DIGIT_W)
  ) u_sub (
    .a          (w_a),
    .b          (w_b),
    .borrow_in  (r_borrow),
    .diff       (w_diff),
    .borrow_out (w_bout)
  );

  assign w_last = (r_idx == IDX_W'(NCHUNK - 1));
  // Padding bits of the top digit are excluded from the non-zero detect.
  // (The borrow out of zero padding equals the borrow out of bit WIDTH-1,
  // so the final borrow needs no correction.)
  assign w_mask     = w_last ? TOP_MASK : {DIGIT_W{1'b1}};
  assign w_acc_next = r_acc | (|(w_diff & w_mask));

`ifdef CMP_SIGNED_EN
  logic w_n;
  logic w_v;
  // Sign of the WIDTH-bit difference and signed overflow, both taken at the
  // real MSB position inside the top digit.
  assign w_n = w_diff[TOP_BITS-1];
  assign w_v = (w_a[TOP_BITS-1] ^ w_b[TOP_BITS-1]) & (w_a[TOP_BITS-1] ^ w_diff[TOP_BITS-1]);
  assign w_carry = r_signed ? ((w_n ^ w_v) & w_acc_next) : (w_bout & w_acc_next);
`else
  assign w_carry = w_bout & w_acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_acc    <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
`ifdef CMP_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= PAD_W'(number1);
            r_b      <= PAD_W'(number2);
`ifdef CMP_SIGNED_EN
            r_signed <= signed_mode;
`endif
            r_borrow <= 1'b0;
            r_acc    <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> DIGIT_W;
          r_b      <= r_b >> DIGIT_W;
          r_borrow <= w_bout;
          r_acc    <= w_acc_next;
          if (w_last) begin
            r_idx   <= '0;
            r_zero  <= ~w_acc_next;
            r_carry <= w_carry;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;

endmodule

// File: tb/tb_seq_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_comparator
// Self-checking bench for seq_comparator: a default-parameter instance and a
// padded instance (DIGIT_W=5) driven with the same operands. Expected flags
// come from plain integer comparison of the operands.
// -----------------------------------------------------------------------------
module tb_seq_comparator;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] number1 = '0;
  logic [W-1:0] number2 = '0;
  logic         signed_mode = 1'b0;
  logic         busy, done, zero_flag, carry_flag;
  logic         busy5, done5, zero5, carry5;

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_z = 1'b0;
  logic prev_c = 1'b0;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(W), .DIGIT_W(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .number1     (number1),
    .number2     (number2),
`ifdef CMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  seq_comparator #(.WIDTH(W), .DIGIT_W(5)) u_dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .number1     (number1),
    .number2     (number2),
`ifdef CMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy5),
    .done        (done5),
    .zero_flag   (zero5),
    .carry_flag  (carry5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_lt(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int sa, sb;
    if (sm) begin
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      return sa < sb;
    end
    return a < b;
  endfunction

  // One full comparison; optionally re-pulses start (with new operands) in
  // the second RUN cycle, which must be ignored.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic repulse);
    logic exp_z, exp_c;
    int   cyc;
    exp_z = (a == b);
    exp_c = (a != b) && model_lt(a, b, sm);
    @(negedge clk);
    number1     = a;
    number2     = b;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    number1 = W'($urandom);
    number2 = W'($urandom);
    cyc = 1;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    while (cyc < 40) begin
      start = (repulse && cyc == 2);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) break;
      check("busy_run", busy, 1);
      check("zero_held_run", zero_flag, prev_z);
      check("carry_held_run", carry_flag, prev_c);
    end
    check("latency", cyc, 6);
    check("busy_done", busy, 1);
    check("zero_flag", zero_flag, exp_z);
    check("carry_flag", carry_flag, exp_c);
    check("zero_flag_pad", zero5, exp_z);
    check("carry_flag_pad", carry5, exp_c);
    @(posedge clk);
    #1;
    check("done_pulse_end", done, 0);
    check("busy_end", busy, 0);
    check("zero_hold", zero_flag, exp_z);
    check("carry_hold", carry_flag, exp_c);
    prev_z = exp_z;
    prev_c = exp_c;
  endtask

  initial begin
    int dcount;
    logic [W-1:0] ra, rb;
    logic rsm;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_carry", carry_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_cmp(18'h2AAAA, 18'h15555, 1'b0, 1'b0);
    run_cmp(18'h15555, 18'h2AAAA, 1'b0, 1'b0);
    run_cmp(18'h33333, 18'h33333, 1'b0, 1'b0);
    run_cmp(18'h00000, 18'h00000, 1'b0, 1'b0);
    run_cmp(18'h3FFFF, 18'h00000, 1'b0, 1'b0);
    run_cmp(18'h00000, 18'h3FFFF, 1'b0, 1'b0);
    run_cmp(18'h20000, 18'h1FFFF, 1'b0, 1'b0);

    // Start while busy is ignored
    run_cmp(18'h00010, 18'h00100, 1'b0, 1'b1);
    run_cmp(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1);

    // Reset in the middle of RUN aborts without a done pulse
    run_cmp(18'h15555, 18'h2AAAA, 1'b0, 1'b0);
    @(negedge clk);
    number1 = 18'h5;
    number2 = 18'h5;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_zero", zero_flag, 0);
    check("abort_carry", carry_flag, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_idle", busy, 0);
    prev_z = 1'b0;
    prev_c = 1'b0;
    run_cmp(18'h00001, 18'h00002, 1'b0, 1'b0);

`ifdef CMP_SIGNED_EN
    run_cmp(18'h20000, 18'h00001, 1'b1, 1'b0);
    run_cmp(18'h20000, 18'h00001, 1'b0, 1'b0);
    run_cmp(18'h1FFFF, 18'h20000, 1'b1, 1'b0);
`endif

    // Randomized comparisons
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
`ifdef CMP_SIGNED_EN
      rsm = 1'($urandom_range(0, 1));
`else
      rsm = 1'b0;
`endif
      run_cmp(ra, rb, rsm, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
